// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
//
// Interrupt controller in front of the 16-bit interrupt input of pipelined_cpu.
// External sources are synchronised, rising-edge detected and latched into a
// pending register. Bit 0 of pending is driven by an internal interval timer.
// A mask gates pending onto the registered irq lines. The CPU programs the
// block through an 8-word MMIO window on its memory write/read ports.
//
// Register map (word offset from BASE_ADDR, byte address bits [1:0] ignored):
//   0 PENDING  read: pending[15:0]; write: 1 clears the bit (per byte lane)
//   1 MASK     read/write bits [15:0]
//   2 RAW      read: {16'b0, synchronised src[14:0], timer_zero}
//   3 SET      write: 1 sets the pending bit (software interrupt); reads 0
//   4 RELOAD   read/write timer reload value; a write also loads COUNT
//   5 COUNT    read: current timer count
//   6 CTRL     bit0 timer_en, bit1 one_shot
//   7 reserved
//
// Parameters:
//   BASE_ADDR    word-aligned base of the MMIO window (32-byte aligned)
//   SYNC_STAGES  synchroniser flops per external source (>= 2)
//   TIMER_W      width of the reload/count registers (1..32)
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   clk_en   CPU enable pulse; timer and MMIO writes only act while high
//   src      external asynchronous sources, rising-edge sensitive -> pending[15:1]
//   mem_we   CPU byte write enables (bit i covers wr_data[8i+7:8i])
//   wr_addr  CPU write byte address
//   wr_data  CPU write data
//   rd_addr  CPU read byte address
//   rd_data  register read data, one clk latency, 0 outside the window
//   rd_hit   rd_addr was inside the window on the previous clk
//   irq      registered pending & mask
// -----------------------------------------------------------------------------
module interrupt_ctrl #(
  parameter logic [17:0] BASE_ADDR   = 18'h3FF00,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMER_W     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [14:0] src,
  input  logic [3:0]  mem_we,
  input  logic [17:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [17:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic [15:0] irq
);

  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_MASK    = 3'd1;
  localparam logic [2:0] OFF_RAW     = 3'd2;
  localparam logic [2:0] OFF_SET     = 3'd3;
  localparam logic [2:0] OFF_RELOAD  = 3'd4;
  localparam logic [2:0] OFF_COUNT   = 3'd5;
  localparam logic [2:0] OFF_CTRL    = 3'd6;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]        pending_reg, pending_next;
  logic [15:0]        mask_reg, mask_next;
  logic [TIMER_W-1:0] reload_reg, reload_next;
  logic [TIMER_W-1:0] count_reg, count_next;
  logic               timer_en_reg, timer_en_next;
  logic               one_shot_reg, one_shot_next;
  logic [14:0]        edge_reg;
  logic [14:0]        prev_reg;
  logic [31:0]        rd_data_reg, rd_data_next;
  logic               rd_hit_reg;
  logic [15:0]        irq_reg;

  // ---------------------------------------------------------------------------
  // Address decode. The window spans 8 words = 32 bytes, so the word offset is
  // addr[4:2] and the window match uses addr[17:5].
  // ---------------------------------------------------------------------------
  logic       wr_in_win;
  logic       rd_in_win;
  logic [2:0] wr_off;
  logic [2:0] rd_off;
  logic       wr_en;

  assign wr_in_win = (wr_addr[17:5] == BASE_ADDR[17:5]);
  assign rd_in_win = (rd_addr[17:5] == BASE_ADDR[17:5]);
  assign wr_off    = wr_addr[4:2];
  assign rd_off    = rd_addr[4:2];
  assign wr_en     = clk_en & wr_in_win & (|mem_we);

  // Byte-lane enable expanded to a bit mask.
  logic [31:0] lane_mask;
  logic [31:0] wdata_masked;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{mem_we[gi]}};
    end
  endgenerate

  assign wdata_masked = wr_data & lane_mask;

  logic wr_pending;
  logic wr_mask;
  logic wr_set;
  logic wr_reload;
  logic wr_ctrl;

  assign wr_pending = wr_en && (wr_off == OFF_PENDING);
  assign wr_mask    = wr_en && (wr_off == OFF_MASK);
  assign wr_set     = wr_en && (wr_off == OFF_SET);
  assign wr_reload  = wr_en && (wr_off == OFF_RELOAD);
  // CTRL bits all live in byte lane 0.
  assign wr_ctrl    = wr_en && (wr_off == OFF_CTRL) && mem_we[0];

  // Address bits [1:0] select a byte within the word and are intentionally
  // ignored by the decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Source synchronisers: one SYNC_STAGES-deep chain per external source.
  // ---------------------------------------------------------------------------
  logic [14:0] sync_src;

  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], src[gi]};
        end
      end

      assign sync_src[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  // Edge detector: edge_reg re-times the synchronised level, prev_reg holds the
  // value one clk older. A rise is flagged for exactly one clk per edge and is
  // independent of clk_en so that no external event is ever missed. Both flops
  // reset to 0, so nothing is flagged on the first clk after reset release.
  logic [14:0] rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_reg <= '0;
      prev_reg <= '0;
    end else begin
      edge_reg <= sync_src;
      prev_reg <= edge_reg;
    end
  end

  assign rise = edge_reg & ~prev_reg;

  // ---------------------------------------------------------------------------
  // Interval timer
  // ---------------------------------------------------------------------------
  logic timer_fire;
  logic timer_zero;
  logic timer_start;

  assign timer_zero  = (count_reg == '0);
  // Enabling the timer through CTRL (0 -> 1) restarts it from RELOAD.
  assign timer_start = wr_ctrl && wr_data[0] && !timer_en_reg;

  always_comb begin
    reload_next = reload_reg;
    if (wr_reload) begin
      reload_next = (reload_reg & ~lane_mask[TIMER_W-1:0]) | wdata_masked[TIMER_W-1:0];
    end
  end

  always_comb begin
    count_next    = count_reg;
    timer_en_next = timer_en_reg;
    one_shot_next = one_shot_reg;
    timer_fire    = 1'b0;

    if (wr_ctrl) begin
      timer_en_next = wr_data[0];
      one_shot_next = wr_data[1];
    end

    // A software load of the counter takes priority over counting.
    if (wr_reload) begin
      count_next = reload_next;
    end else if (timer_start) begin
      count_next = reload_reg;
    end else if (clk_en && timer_en_reg) begin
      if (timer_zero) begin
        count_next = reload_reg;
        timer_fire = 1'b1;
        // One-shot mode stops itself unless software rewrites CTRL this clk.
        if (one_shot_reg && !wr_ctrl) begin
          timer_en_next = 1'b0;
        end
      end else begin
        count_next = count_reg - TIMER_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending and mask. Sets are ORed in after the clear so an event arriving in
  // the same clk as a software clear of that bit is never lost.
  // ---------------------------------------------------------------------------
  logic [15:0] pending_clr;
  logic [15:0] pending_sw_set;

  assign pending_clr    = wr_pending ? wdata_masked[15:0] : 16'h0000;
  assign pending_sw_set = wr_set     ? wdata_masked[15:0] : 16'h0000;

  always_comb begin
    pending_next = (pending_reg & ~pending_clr)
                 | {rise, 1'b0}
                 | pending_sw_set
                 | {15'b0, timer_fire};
  end

  always_comb begin
    mask_next = mask_reg;
    if (wr_mask) begin
      mask_next = (mask_reg & ~lane_mask[15:0]) | wdata_masked[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: samples current register state, so a read in the same clk as a
  // write returns the value from before the write. Not gated by clk_en.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_next = 32'h0000_0000;
    if (rd_in_win) begin
      case (rd_off)
        OFF_PENDING: rd_data_next = {16'h0000, pending_reg};
        OFF_MASK:    rd_data_next = {16'h0000, mask_reg};
        OFF_RAW:     rd_data_next = {16'h0000, sync_src, timer_zero};
        OFF_RELOAD:  rd_data_next = 32'(reload_reg);
        OFF_COUNT:   rd_data_next = 32'(count_reg);
        OFF_CTRL:    rd_data_next = {30'b0, one_shot_reg, timer_en_reg};
        default:     rd_data_next = 32'h0000_0000;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= '0;
      mask_reg     <= '0;
      reload_reg   <= '0;
      count_reg    <= '0;
      timer_en_reg <= 1'b0;
      one_shot_reg <= 1'b0;
      rd_data_reg  <= '0;
      rd_hit_reg   <= 1'b0;
      irq_reg      <= '0;
    end else begin
      pending_reg  <= pending_next;
      mask_reg     <= mask_next;
      reload_reg   <= reload_next;
      count_reg    <= count_next;
      timer_en_reg <= timer_en_next;
      one_shot_reg <= one_shot_next;
      rd_data_reg  <= rd_data_next;
      rd_hit_reg   <= rd_in_win;
      // Computed from next-state values so irq follows the causing event by
      // exactly one clk, including unmasking of an already pending bit.
      irq_reg      <= pending_next & mask_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign rd_hit  = rd_hit_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

  localparam logic [17:0] BASE = 18'h3FF00;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [14:0] src;
  logic [3:0]  mem_we;
  logic [17:0] wr_addr;
  logic [31:0] wr_data;
  logic [17:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [15:0] irq;

  interrupt_ctrl #(
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(2),
    .TIMER_W    (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .src    (src),
    .mem_we (mem_we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_hit (rd_hit),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        hit;
  } rd_exp_t;

  typedef struct {
    string       name;
    logic [15:0] irq;
  } irq_exp_t;

  // Scoreboard queues: expectations are pushed when stimulus is driven and
  // popped once the DUT has registered its response.
  rd_exp_t  rd_q[$];
  irq_exp_t irq_q[$];

  typedef struct {
    logic        en;
    logic [17:0] waddr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [17:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [15:0] exp_irq;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic logic [17:0] ra(input int off);
    return BASE + 18'(off * 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    rd_exp_t  re;
    irq_exp_t ie;
    @(posedge clk);
    #1;
    if (rd_q.size() > 0) begin
      re = rd_q.pop_front();
      check(re.name, rd_data, re.data);
      check({re.name, "_hit"}, {31'b0, rd_hit}, {31'b0, re.hit});
    end
    if (irq_q.size() > 0) begin
      ie = irq_q.pop_front();
      check(ie.name, {16'b0, irq}, {16'b0, ie.irq});
    end
  endtask

  task automatic mmio_write(input int off, input logic [31:0] data, input logic [3:0] we);
    clk_en  = 1'b1;
    wr_addr = ra(off);
    wr_data = data;
    mem_we  = we;
    step();
    mem_we  = 4'b0000;
    wr_data = 32'h0;
  endtask

  task automatic read_chk(input string name, input int off, input logic [31:0] exp);
    rd_addr = ra(off);
    rd_q.push_back('{name, exp, 1'b1});
    step();
  endtask

  task automatic exp_irq(input string name, input logic [15:0] v);
    irq_q.push_back('{name, v});
  endtask

  initial begin
    bit exp_t;

    rst_n   = 1'b0;
    clk_en  = 1'b1;
    src     = 15'h7FFF;
    mem_we  = 4'b0000;
    wr_addr = 18'h0;
    wr_data = 32'h0;
    rd_addr = ra(0);

    // {en, waddr, we, wdata, raddr, exp_rd (pre-write state), exp_hit, exp_irq}
    vecs[0]  = '{1'b1, ra(1), 4'b0001, 32'hFFFF_FFFF, ra(1), 32'h0000_0000, 1'b1, 16'h0000};
    vecs[1]  = '{1'b1, ra(0), 4'b0000, 32'h0,         ra(1), 32'h0000_00FF, 1'b1, 16'h0000};
    vecs[2]  = '{1'b1, ra(3), 4'b0011, 32'h0000_8000, ra(0), 32'h0000_0000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, ra(0), 4'b0000, 32'h0,         ra(0), 32'h0000_8000, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, ra(1), 4'b0010, 32'h0000_8000, ra(3), 32'h0000_0000, 1'b1, 16'h8000};
    vecs[5]  = '{1'b1, ra(0), 4'b0000, 32'h0,         ra(1) + 18'd2, 32'h0000_80FF, 1'b1, 16'h8000};
    vecs[6]  = '{1'b1, BASE + 18'h20, 4'b1111, 32'hFFFF_FFFF, BASE - 18'd4, 32'h0, 1'b0, 16'h8000};
    vecs[7]  = '{1'b1, ra(0), 4'b0000, 32'h0,         ra(2), 32'h0000_0001, 1'b1, 16'h8000};
    vecs[8]  = '{1'b1, ra(7), 4'b1111, 32'hFFFF_FFFF, ra(7), 32'h0000_0000, 1'b1, 16'h8000};
    vecs[9]  = '{1'b1, ra(0), 4'b0001, 32'h0000_8000, ra(0), 32'h0000_8000, 1'b1, 16'h8000};
    vecs[10] = '{1'b1, ra(0), 4'b0010, 32'h0000_8000, ra(0), 32'h0000_8000, 1'b1, 16'h0000};
    vecs[11] = '{1'b1, ra(4), 4'b0101, 32'h1234_5678, ra(0), 32'h0000_0000, 1'b1, 16'h0000};
    vecs[12] = '{1'b1, ra(0), 4'b0000, 32'h0,         ra(4), 32'h0034_0078, 1'b1, 16'h0000};
    vecs[13] = '{1'b1, ra(0), 4'b0000, 32'h0,         ra(5), 32'h0034_0078, 1'b1, 16'h0000};
    vecs[14] = '{1'b0, ra(1), 4'b1111, 32'h0,         ra(0), 32'h0000_0000, 1'b1, 16'h0000};
    vecs[15] = '{1'b1, ra(0), 4'b0000, 32'h0,         ra(1), 32'h0000_80FF, 1'b1, 16'h0000};
    vecs[16] = '{1'b1, ra(1), 4'b1111, 32'h0,         ra(6), 32'h0000_0000, 1'b1, 16'h0000};
    vecs[17] = '{1'b1, ra(0), 4'b0000, 32'h0,         ra(1), 32'h0000_0000, 1'b1, 16'h0000};

    // ---- Reset with all sources held high ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", {16'b0, irq}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_hit", {31'b0, rd_hit}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back('{$sformatf("post_rst_pend%0d", i), 32'h0, 1'b1});
      exp_irq($sformatf("post_rst_irq%0d", i), 16'h0000);
      step();
    end
    step();
    step();
    src = 15'h0000;
    step();
    step();
    mmio_write(0, 32'h0000_FFFF, 4'b0011);

    // ---- Register map / byte lanes / SET / gating table ----
    for (int i = 0; i < NV; i++) begin
      clk_en  = vecs[i].en;
      wr_addr = vecs[i].waddr;
      mem_we  = vecs[i].we;
      wr_data = vecs[i].wdata;
      rd_addr = vecs[i].raddr;
      rd_q.push_back('{$sformatf("vec%0d_rd", i), vecs[i].exp_rd, vecs[i].exp_hit});
      exp_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
      step();
    end
    mem_we = 4'b0000;
    clk_en = 1'b1;

    // ---- Edge detect latency, hold, W1C without re-trigger ----
    mmio_write(1, 32'h0000_0004, 4'b1111);
    src = 15'h0002;
    exp_irq("edge_lat1", 16'h0000);
    step();
    src = 15'h0000;
    exp_irq("edge_lat2", 16'h0000);
    step();
    exp_irq("edge_lat3", 16'h0000);
    step();
    exp_irq("edge_lat4", 16'h0004);
    step();
    src = 15'h0002;
    for (int i = 0; i < 8; i++) begin
      exp_irq($sformatf("edge_hold%0d", i), 16'h0004);
      step();
    end
    exp_irq("edge_w1c", 16'h0000);
    mmio_write(0, 32'h0000_0004, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      exp_irq($sformatf("edge_noretrig%0d", i), 16'h0000);
      step();
    end
    src = 15'h0000;

    // ---- Masked source stays pending, asserts irq when unmasked ----
    mmio_write(1, 32'h0, 4'b1111);
    src = 15'h0010;
    for (int i = 0; i < 6; i++) begin
      exp_irq($sformatf("mask_off%0d", i), 16'h0000);
      step();
    end
    read_chk("mask_pending", 0, 32'h0000_0020);
    exp_irq("mask_unmask", 16'h0020);
    mmio_write(1, 32'h0000_0020, 4'b1111);
    src = 15'h0000;
    exp_irq("mask_clr", 16'h0000);
    mmio_write(0, 32'h0000_0020, 4'b1111);
    mmio_write(1, 32'h0, 4'b1111);

    // ---- Collision: clear of bit 3 in the clk src[2] rise is seen ----
    mmio_write(3, 32'h0000_0008, 4'b1111);
    src = 15'h0004;
    step();
    step();
    step();
    mmio_write(0, 32'h0000_0008, 4'b1111);
    read_chk("collision_pending", 0, 32'h0000_0008);
    mmio_write(0, 32'h0000_0008, 4'b1111);
    read_chk("plain_clear_pending", 0, 32'h0000_0000);
    src = 15'h0000;

    // ---- Periodic timer with clk_en every 4th clk ----
    mmio_write(1, 32'h0000_0001, 4'b1111);
    mmio_write(0, 32'h0000_FFFF, 4'b1111);
    mmio_write(4, 32'h0000_0003, 4'b1111);
    read_chk("timer_count_load", 5, 32'h0000_0003);
    mmio_write(6, 32'h0000_0001, 4'b1111);
    for (int c = 0; c < 48; c++) begin
      clk_en = ((c % 4) == 3);
      if (c == 19 || c == 35) begin
        wr_addr = ra(0);
        wr_data = 32'h0000_0001;
        mem_we  = 4'b1111;
      end
      exp_t = (c >= 15) && (((c % 16) == 15) || ((c % 16) < 3));
      exp_irq($sformatf("timer_c%0d", c), {15'b0, exp_t});
      step();
      mem_we  = 4'b0000;
      wr_data = 32'h0;
    end
    clk_en = 1'b1;

    // ---- One-shot timer ----
    mmio_write(6, 32'h0, 4'b1111);
    mmio_write(0, 32'h0000_FFFF, 4'b1111);
    exp_irq("oneshot_start", 16'h0000);
    mmio_write(6, 32'h0000_0003, 4'b1111);
    for (int k = 1; k <= 4; k++) begin
      exp_irq($sformatf("oneshot_k%0d", k), (k == 4) ? 16'h0001 : 16'h0000);
      step();
    end
    exp_irq("oneshot_clr", 16'h0000);
    mmio_write(0, 32'h0000_0001, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      exp_irq($sformatf("oneshot_quiet%0d", i), 16'h0000);
      step();
    end
    read_chk("oneshot_ctrl", 6, 32'h0000_0002);
    read_chk("oneshot_count", 5, 32'h0000_0003);

    // ---- Reset mid-count with pending bits ----
    mmio_write(1, 32'h0000_FFFF, 4'b1111);
    mmio_write(6, 32'h0000_0001, 4'b1111);
    exp_irq("pre_rst_irq", 16'h0102);
    mmio_write(3, 32'h0000_0102, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_irq", {16'b0, irq}, 32'h0);
    check("midrst_rd_data", rd_data, 32'h0);
    step();
    rst_n = 1'b1;
    read_chk("after_rst_pending", 0, 32'h0);
    read_chk("after_rst_mask", 1, 32'h0);
    read_chk("after_rst_ctrl", 6, 32'h0);
    read_chk("after_rst_count", 5, 32'h0);
    read_chk("after_rst_raw", 2, 32'h0000_0001);

    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", rd_q.size(), irq_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
